// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V pipeline front end.
//   XLEN           - architectural word / address width
//   NOP_INSTR      - bubble encoding (ADDI x0,x0,0)
//   fetch_state_t  - fetch FSM state encoding
//   is_word_aligned- true when a byte address is 4-byte aligned
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load              - capture pc_in / instr_in as a valid instruction
//   flush             - turn the register into a bubble (pc fields hold)
//   pc_in, instr_in   - fetched PC and instruction word
//   pc, pc_plus4      - PC of held instruction and PC+4 (mod 2^32)
//   instr, valid      - held instruction and valid flag
// flush has priority over load; with neither asserted everything holds.
module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic            valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (load) begin
            r_pc       <= pc_in;
            r_pc_plus4 <= pc_in + 32'd4;
            r_instr    <= instr_in;
            r_valid    <= 1'b1;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = r_pc_plus4;
    assign instr    = r_instr;
    assign valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID register.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   imem_addr / imem_instr      - byte address out (= PC), instruction in
//   stall                       - hold PC and IF/ID
//   redirect_valid/redirect_pc  - taken branch/jump target, flushes IF/ID
//   if_id_pc, if_id_pc_plus4,
//   if_id_instr, if_id_valid    - IF/ID register contents
//   fault                       - sticky fetch fault (terminal until reset)
//   fetch_count                 - instructions accepted into IF/ID, wrapping
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS = 32,
    parameter logic [XLEN-1:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            fault,
    output logic [XLEN-1:0] fetch_count
);

    // First byte address past the end of instruction memory.
    localparam logic [XLEN-1:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_fetch_count;
    logic [XLEN-1:0] w_fetch_count_next;
    logic            w_load;
    logic            w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    // Priority in RUN: redirect > stall > advance. BOOT and FAULT keep
    // IF/ID as a bubble and ignore every input.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_count_next = r_fetch_count;
        w_load             = 1'b0;
        w_flush            = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_flush      = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (is_word_aligned(redirect_pc)) begin
                        w_pc_next = redirect_pc;
                    end else begin
                        w_state_next = FAULT;
                    end
                end else if (stall) begin
                    // everything holds
                end else if (r_pc >= IMEM_BYTES) begin
                    w_flush      = 1'b1;
                    w_state_next = FAULT;
                end else begin
                    w_load             = 1'b1;
                    w_pc_next          = r_pc + 32'd4;
                    w_fetch_count_next = r_fetch_count + 32'd1;
                end
            end
            FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                // Unreachable encoding: park safely in FAULT.
                w_flush      = 1'b1;
                w_state_next = FAULT;
            end
        endcase
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .flush    (w_flush),
        .pc_in    (r_pc),
        .instr_in (imem_instr),
        .pc       (if_id_pc),
        .pc_plus4 (if_id_pc_plus4),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fault       = (r_state == FAULT);
    assign fetch_count = r_fetch_count;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the 5-stage RISC-V pipeline.
- Owns the PC register and drives the byte address into the combinational, word-addressed instruction memory. It samples the returned instruction into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect with flush, and bounds/alignment faults on the fetch address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 32, number of 32-bit words in instruction memory. Legal fetch range is 0 .. IMEM_WORDS*4-4.
- NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; combinationally equal to the PC register.
- imem_instr  input  32  instruction word returned combinationally by instruction memory.
- stall  input  1  hazard unit hold request; freezes PC and IF/ID.
- redirect_valid  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  32  target byte address for the redirect.
- if_id_pc  output  32  PC of the instruction held in IF/ID.
- if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
- fault  output  1  sticky fetch fault (misaligned redirect or out-of-range PC).
- fetch_count  output  32  number of instructions accepted into IF/ID, wrapping.

Behaviour:
- Reset (async, rst=1):
  - State BOOT, pc=RESET_PC.
  - if_id_pc=RESET_PC, if_id_pc_plus4=RESET_PC+4.
  - if_id_instr=NOP_INSTR, if_id_valid=0, fault=0, fetch_count=0.
  - Reset asserted mid-operation discards everything immediately.
- BOOT: one cycle after rst deasserts. IF/ID is held as a bubble and pc holds. Unconditional transition to RUN; stall and redirect are ignored in BOOT. This covers instruction memory returning NOP while in reset.
- RUN, evaluated on each rising edge with priority redirect > stall > advance:
  - Redirect with redirect_valid=1 and redirect_pc[1:0]==0: pc<=redirect_pc. IF/ID is flushed: if_id_valid<=0, if_id_instr<=NOP_INSTR, pc fields hold. A redirect overrides a simultaneous stall.
  - Redirect with redirect_valid=1 and redirect_pc[1:0]!=0: go to FAULT and set fault<=1. pc holds, and IF/ID is flushed as above.
  - Stall with stall=1 and no redirect: pc, the IF/ID fields and fetch_count all hold.
  - Advance, out of range: if pc >= IMEM_WORDS*4, go to FAULT. fault<=1, IF/ID is flushed, and pc holds.
  - Advance, in range: IF/ID loads instr=imem_instr, pc=pc, pc_plus4=pc+4, valid=1. Then pc<=pc+4 and fetch_count<=fetch_count+1.
- FAULT: terminal until rst.
  - fault=1, if_id_valid=0, if_id_instr=NOP_INSTR.
  - pc and fetch_count are frozen, and all inputs are ignored.
- Latency: an instruction at PC p appears in IF/ID one cycle after the edge at which pc==p in RUN with no stall. Throughput is 1 per cycle.
- Arithmetic: PC additions are 32-bit unsigned, wrap mod 2^32, no carry out. The range check is an unsigned compare.
- imem_addr must have no registered delay relative to pc.

Decomposition:
- Shared package (rv_pkg):
  - NOP_INSTR constant.
  - Fetch-state encoding: BOOT=2'd0, RUN=2'd1, FAULT=2'd2.
  - Word/address width constants (XLEN=32).
- One natural sub-module: if_id_reg, the IF/ID register with load, hold and flush controls and async reset. The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset then release, with memory holding words 0x11,0x22,0x33 at addresses 0,4,8:
  - Cycle 1 after release: if_id_valid=0 (BOOT).
  - Next cycles: if_id_instr=0x11, 0x22, 0x33 with if_id_pc=0, 4, 8 and fetch_count=1, 2, 3.
- Stall held 3 cycles while if_id_pc=4: IF/ID stays 0x22/pc 4 and imem_addr stays 8. On release, 0x33/pc 8 follows next cycle.
- Redirect to 0x40 asserted together with stall: next edge gives if_id_valid=0 and imem_addr=0x40. The following edge loads the instruction at 0x40 with if_id_pc=0x40.
- Redirect to 0x42: fault=1 next edge, if_id_valid=0. pc and fetch_count remain frozen for 10 cycles regardless of stall/redirect. Asserting rst clears fault and sets pc=0.
- Sequential fetch to pc=0x7C with IMEM_WORDS=32: 0x7C is fetched normally. At pc=0x80, fault=1 and fetch_count=32.
- Assert rst asynchronously mid-cycle during RUN: outputs reach reset values before the next clock edge, and imem_addr=RESET_PC.
